// File: rtl/zxuno_audio_mixer_n_pkg.sv
// Shared definitions for the N-channel audio mixer: ZX-Uno register map,
// FSM state encoding and the status register layout.
package zxuno_audio_mixer_n_pkg;

  // ZX-Uno register map entries owned by the mixer
  localparam logic [7:0] ZXUNO_REG_MIX_SEL  = 8'hF8;
  localparam logic [7:0] ZXUNO_REG_MIX_GAIN = 8'hF9;

  // Gain is a fixed-point value with this many fraction bits (8 = unity)
  localparam int unsigned GAIN_FRAC_BITS = 3;

  typedef enum logic [1:0] {
    MIX_IDLE  = 2'd0,
    MIX_ACC   = 2'd1,
    MIX_SCALE = 2'd2
  } mix_state_e;

  typedef struct packed {
    logic       overrun;
    logic [1:0] rsvd;
    logic [4:0] sel;
  } mix_status_t;

  function automatic logic [7:0] pack_status(input logic overrun, input logic [4:0] sel);
    mix_status_t st;
    st.overrun = overrun;
    st.rsvd    = 2'b00;
    st.sel     = sel;
    return st;
  endfunction

endpackage

// File: rtl/zxuno_sigma_delta_dac.sv
// First-order sigma-delta modulator: the carry of a W-bit accumulator
// is the 1-bit DAC stream.
module zxuno_sigma_delta_dac #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic         dout
);

  logic [W-1:0] sd_acc_q;
  logic [W:0]   sum_c;

  assign sum_c = {1'b0, sd_acc_q} + {1'b0, din};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sd_acc_q <= '0;
      dout     <= 1'b0;
    end else begin
      sd_acc_q <= sum_c[W-1:0];
      dout     <= sum_c[W];
    end
  end

endmodule

// File: rtl/zxuno_audio_mixer_n.sv
// N-channel time-multiplexed audio mixer with per-channel gain set through
// ZX-Uno registers, saturating output and a sigma-delta DAC pin.
module zxuno_audio_mixer_n
  import zxuno_audio_mixer_n_pkg::*;
#(
  parameter int unsigned NCH      = 4,
  parameter int unsigned W        = 8,
  parameter int unsigned GW       = 4,
  parameter int unsigned SHIFT    = 2,
  parameter logic [7:0]  REG_SEL  = ZXUNO_REG_MIX_SEL,
  parameter logic [7:0]  REG_GAIN = ZXUNO_REG_MIX_GAIN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_en,
  input  logic [NCH*W-1:0] ch_in,
  input  logic [7:0]       zxuno_addr,
  input  logic             zxuno_regrd,
  input  logic             zxuno_regwr,
  input  logic [7:0]       din,
  output logic [7:0]       dout,
  output logic             oe_n,
  output logic [W-1:0]     mix_out,
  output logic             mix_valid,
  output logic             audio_out
);

  localparam int unsigned SW = $clog2(NCH);
  localparam int unsigned PW = W + GW;
  localparam int unsigned AW = W + GW + SW;

  mix_state_e    state_q, state_d;
  logic [SW-1:0] sel_q;
  logic [SW-1:0] idx_q, idx_d;
  logic          overrun_q;
  logic [GW-1:0] gain_q [NCH];
  logic [W-1:0]  snap_q [NCH];
  logic [AW-1:0] acc_q, acc_d;
  logic [W-1:0]  mix_out_d;
  logic          mix_valid_d;
  logic          snap_en_c;

  logic          sel_hit_c, gain_hit_c, sel_ok_c;
  logic [PW-1:0] prod_c;
  logic [AW-1:0] scaled_c;
  logic [7:0]    gain_rd_c;

  assign sel_hit_c  = (zxuno_addr == REG_SEL);
  assign gain_hit_c = (zxuno_addr == REG_GAIN);
  assign sel_ok_c   = (32'(sel_q) < NCH);

  // Register read port is combinational so data and oe_n line up with the strobe
  assign gain_rd_c = sel_ok_c ? 8'(gain_q[sel_q]) : 8'h00;
  assign oe_n      = ~(zxuno_regrd & (sel_hit_c | gain_hit_c));
  always_comb begin
    dout = 8'h00;
    if (zxuno_regrd && sel_hit_c)
      dout = pack_status(overrun_q, 5'(sel_q));
    else if (zxuno_regrd && gain_hit_c)
      dout = gain_rd_c;
  end

  assign prod_c   = PW'(snap_q[idx_q]) * PW'(gain_q[idx_q]);
  assign scaled_c = acc_q >> (GAIN_FRAC_BITS + SHIFT);

  // Next-state and datapath control
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    mix_out_d   = mix_out;
    mix_valid_d = 1'b0;
    snap_en_c   = 1'b0;
    case (state_q)
      MIX_IDLE: begin
        if (sample_en) begin
          snap_en_c = 1'b1;
          acc_d     = '0;
          idx_d     = '0;
          state_d   = MIX_ACC;
        end
      end
      MIX_ACC: begin
        acc_d = acc_q + AW'(prod_c);
        idx_d = idx_q + SW'(1);
        if (idx_q == SW'(NCH - 1))
          state_d = MIX_SCALE;
      end
      MIX_SCALE: begin
        mix_out_d   = (|scaled_c[AW-1:W]) ? '1 : scaled_c[W-1:0];
        mix_valid_d = 1'b1;
        state_d     = MIX_IDLE;
      end
      default: state_d = MIX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MIX_IDLE;
      idx_q     <= '0;
      acc_q     <= '0;
      mix_out   <= '0;
      mix_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      mix_out   <= mix_out_d;
      mix_valid <= mix_valid_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) snap_q[k] <= '0;
    end else if (snap_en_c) begin
      for (int k = 0; k < NCH; k++) snap_q[k] <= ch_in[k*W +: W];
    end
  end

  // Control registers; a sample dropped outside IDLE wins over a clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q     <= '0;
      overrun_q <= 1'b0;
      for (int k = 0; k < NCH; k++) gain_q[k] <= GW'(8);
    end else begin
      if (zxuno_regwr && sel_hit_c)
        sel_q <= din[SW-1:0];
      if (sample_en && (state_q != MIX_IDLE))
        overrun_q <= 1'b1;
      else if (zxuno_regwr && sel_hit_c && din[7])
        overrun_q <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        if (zxuno_regwr && gain_hit_c && sel_ok_c && (sel_q == SW'(k)))
          gain_q[k] <= din[GW-1:0];
      end
    end
  end

  zxuno_sigma_delta_dac #(.W(W)) u_dac (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (mix_out),
    .dout  (audio_out)
  );

endmodule
